// File: rtl/moka_rv32i_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : moka_rv32i_mc_controller
// Brief   : Multicycle RV32I control FSM with stall-aware memory handshake,
//           illegal-instruction trap and retired-instruction counter.
// Rev     : 1.0
// ============================================================================
module moka_rv32i_mc_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [3:0]           ALUControl,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;
  localparam logic [3:0] c_ALU_AND = 4'b0010;
  localparam logic [3:0] c_ALU_OR  = 4'b0011;
  localparam logic [3:0] c_ALU_XOR = 4'b0100;
  localparam logic [3:0] c_ALU_SLT = 4'b0101;
  localparam logic [3:0] c_ALU_SLL = 4'b0110;
  localparam logic [3:0] c_ALU_SRL = 4'b0111;
  localparam logic [3:0] c_ALU_SRA = 4'b1000;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  state_t               w_dec_next;
  logic                 w_retire;
  logic [3:0]           w_alu_fn;
  logic [CNT_WIDTH-1:0] r_instret;

  // Opcode/funct3 legality check folded into the DECODE successor choice.
  always_comb begin
    w_dec_next = S_ILLEGAL;
    case (op)
      c_OP_LOAD, c_OP_STORE: if (funct3 == 3'b010) w_dec_next = S_MEMADR;
      c_OP_RTYPE:            if (funct3 != 3'b011) w_dec_next = S_EXECUTER;
      c_OP_ITYPE:            if (funct3 != 3'b011) w_dec_next = S_EXECUTEI;
      c_OP_BRANCH:           if (funct3 == 3'b000) w_dec_next = S_BEQ;
      c_OP_JAL:              w_dec_next = S_JAL;
      default:               w_dec_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE:   w_next = w_dec_next;
      S_MEMADR:   w_next = (op == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWRITE: if (mem_ready) begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_EXECUTER, S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // Subtract only for register-register add; immediates have no subi.
  always_comb begin
    w_alu_fn = c_ALU_ADD;
    case (funct3)
      3'b000:  w_alu_fn = (r_state == S_EXECUTER && funct7) ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  w_alu_fn = c_ALU_SLL;
      3'b010:  w_alu_fn = c_ALU_SLT;
      3'b100:  w_alu_fn = c_ALU_XOR;
      3'b101:  w_alu_fn = funct7 ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  w_alu_fn = c_ALU_OR;
      3'b111:  w_alu_fn = c_ALU_AND;
      default: w_alu_fn = c_ALU_ADD;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = c_ALU_ADD;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == c_OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_fn;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_fn;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = c_ALU_SUB;
        PCWrite    = zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ImmSrc  = 2'b11;
        PCWrite = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + c_CNT_ONE;
    end
  end

  assign instret   = r_instret;
  assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_moka_rv32i_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_moka_rv32i_mc_controller
// Brief   : Randomized instruction-level bench with a per-instruction path model.
// Rev     : 1.0
// ============================================================================
module tb_moka_rv32i_mc_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0]    ALUControl, dbg_state;
  logic [CW-1:0] instret;

  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] m_instret;

  moka_rv32i_mc_controller #(.CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .instret(instret), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom & 1);
  endfunction

  function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7, bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // Expected control word per state, straight from the per-state output table.
  function automatic logic [18:0] exp_out(logic [3:0] st, logic [6:0] o, logic [2:0] f3,
                                          logic f7, logic z, logic mr);
    logic mq = 0, ad = 0, mw = 0, ir = 0, pc = 0, rw = 0, il = 0;
    logic [1:0] sa = 0, sb = 0, rs = 0, im = 0;
    logic [3:0] al = 0;
    case (st)
      4'd0:  begin mq = 1; sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; im = 2'b10; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; im = (o == ST) ? 2'b01 : 2'b00; end
      4'd3:  begin mq = 1; ad = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin mq = 1; ad = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; al = alu_of(f3, f7, 1'b1); end
      4'd7:  begin sa = 2'b10; sb = 2'b01; al = alu_of(f3, f7, 1'b0); end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2'b10; al = 4'd1; pc = z; end
      4'd10: begin sa = 2'b01; sb = 2'b10; im = 2'b11; pc = 1; end
      4'd11: il = 1;
      default: ;
    endcase
    return {mq, ad, mw, ir, pc, rw, sa, sb, rs, im, al, il};
  endfunction

  task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input bit ret);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    chk($sformatf("st%0d_state", st), {28'd0, dbg_state}, {28'd0, st});
    chk($sformatf("st%0d_ctrl", st),
        {13'd0, mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
         ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal},
        {13'd0, exp_out(st, op, funct3, funct7, z, mr)});
    chk($sformatf("st%0d_instret", st), {28'd0, instret}, {28'd0, m_instret});
    @(posedge clk);
    #1;
    if (ret) m_instret = m_instret + 1'b1;
  endtask

  task automatic fetch_decode(input int wf);
    repeat (wf) cyc(4'd0, 1'b0, rb(), 1'b0);
    cyc(4'd0, 1'b1, rb(), 1'b0);
    cyc(4'd1, rb(), rb(), 1'b0);
  endtask

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal; negative args mean random.
  task automatic run_instr(input int kind, input int wf, input int wm,
                           input int f3s, input int f7s, input int zs);
    logic zb;
    funct7 = (f7s < 0) ? logic'(rb()) : logic'(f7s[0]);
    case (kind)
      0: begin op = LD; funct3 = 3'd2; end
      1: begin op = ST; funct3 = 3'd2; end
      2, 3: begin
        op = (kind == 2) ? RT : IT;
        if (f3s >= 0) funct3 = 3'(f3s);
        else do funct3 = 3'($urandom); while (funct3 == 3'd3);
      end
      4: begin op = BR; funct3 = 3'd0; end
      default: begin op = JL; funct3 = 3'($urandom); end
    endcase
    if (wf < 0) wf = $urandom_range(0, 2);
    if (wm < 0) wm = $urandom_range(0, 2);
    zb = (zs < 0) ? logic'(rb()) : logic'(zs[0]);
    fetch_decode(wf);
    case (kind)
      0: begin
        cyc(4'd2, rb(), rb(), 1'b0);
        repeat (wm) cyc(4'd3, 1'b0, rb(), 1'b0);
        cyc(4'd3, 1'b1, rb(), 1'b0);
        cyc(4'd4, rb(), rb(), 1'b1);
      end
      1: begin
        cyc(4'd2, rb(), rb(), 1'b0);
        repeat (wm) cyc(4'd5, 1'b0, rb(), 1'b0);
        cyc(4'd5, 1'b1, rb(), 1'b1);
      end
      2: begin cyc(4'd6, rb(), rb(), 1'b0); cyc(4'd8, rb(), rb(), 1'b1); end
      3: begin cyc(4'd7, rb(), rb(), 1'b0); cyc(4'd8, rb(), rb(), 1'b1); end
      4: cyc(4'd9, rb(), zb, 1'b1);
      default: begin cyc(4'd10, rb(), rb(), 1'b0); cyc(4'd8, rb(), rb(), 1'b1); end
    endcase
  endtask

  task automatic reset_in(input logic [3:0] st, input logic mr);
    rst = 1'b1;
    cyc(st, mr, rb(), 1'b0);
    rst = 1'b0;
    m_instret = '0;
  endtask

  function automatic bit legal_op(logic [6:0] o);
    return o == LD || o == ST || o == RT || o == IT || o == BR || o == JL;
  endfunction

  task automatic run_illegal(input int sel, input int hold);
    funct7 = rb();
    case (sel)
      0: begin do op = 7'($urandom); while (legal_op(op)); funct3 = 3'($urandom); end
      1: begin op = rb() ? RT : IT; funct3 = 3'd3; end
      2: begin op = rb() ? LD : ST; do funct3 = 3'($urandom); while (funct3 == 3'd2); end
      default: begin op = BR; do funct3 = 3'($urandom); while (funct3 == 3'd0); end
    endcase
    fetch_decode($urandom_range(0, 1));
    repeat (hold) cyc(4'd11, rb(), rb(), 1'b0);
    reset_in(4'd11, rb());
  endtask

  task automatic run_rst_mid(input bit store);
    op = store ? ST : LD;
    funct3 = 3'd2;
    funct7 = rb();
    fetch_decode(0);
    cyc(4'd2, rb(), rb(), 1'b0);
    cyc(store ? 4'd5 : 4'd3, 1'b0, rb(), 1'b0);
    reset_in(store ? 4'd5 : 4'd3, 1'b0);
  endtask

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    m_instret = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(0, 0, 0, -1, -1, -1);
    run_instr(1, 0, 3, -1, -1, -1);
    run_instr(2, 0, 0, 0, 1, -1);
    run_instr(3, 0, 0, 5, 1, -1);
    run_instr(3, 0, 0, 0, 1, -1);
    run_instr(4, 0, 0, -1, -1, 1);
    run_instr(4, 0, 0, -1, -1, 0);
    run_instr(5, 0, 0, -1, -1, -1);

    op = 7'b1111111; funct3 = 3'd0; funct7 = 1'b0;
    fetch_decode(0);
    repeat (10) cyc(4'd11, rb(), rb(), 1'b0);
    reset_in(4'd11, 1'b1);

    for (int i = 0; i < 16; i++) run_instr($urandom_range(0, 5), 0, 0, -1, -1, -1);
    run_instr(5, 0, 0, -1, -1, -1);

    run_rst_mid(1'b0);
    run_rst_mid(1'b1);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5)      run_instr(k, -1, -1, -1, -1, -1);
      else if (k == 6) run_illegal($urandom_range(0, 3), $urandom_range(1, 4));
      else if (k == 7) run_rst_mid(rb());
      else             run_instr($urandom_range(0, 5), 0, 0, -1, -1, -1);
    end
    run_instr(0, 0, 0, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moka_rv32i_mc_controller.md
MOKA_RV32I_MC_CONTROLLER -- requirements
Module: moka_rv32i_mc_controller

Interface
REQ-001 Parameter: CNT_WIDTH, 32, width of retired-instruction counter.
REQ-002 Ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 Ports: rst  in  1  reset, synchronous, active-high.
REQ-004 Ports: op  in  7  instruction opcode; funct3  in  3; funct7  in  1  instruction bit 30.
REQ-005 Ports: zero  in  1  ALU zero flag; mem_ready  in  1  shared memory completes access this cycle.
REQ-006 Ports: mem_req  out  1  memory access request; AdrSrc  out  1  memory address select (0 PC, 1 ALUOut); MemWrite  out  1  store strobe.
REQ-007 Ports: IRWrite  out  1  latch instruction and OldPC; PCWrite  out  1  PC load enable; RegWrite  out  1  register file write enable.
REQ-008 Ports: ALUSrcA  out  2  (00 PC, 01 OldPC, 10 RD1); ALUSrcB  out  2  (00 RD2, 01 ImmExt, 10 constant 4).
REQ-009 Ports: ResultSrc  out  2  (00 ALUOut, 01 ReadData, 10 ALUResult); ImmSrc  out  2  (00 I, 01 S, 10 B, 11 J).
REQ-010 Ports: ALUControl  out  4  (0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra).
REQ-011 Ports: illegal  out  1  sticky illegal-instruction flag; instret  out  CNT_WIDTH  retired count; dbg_state  out  4  current state code.

Function
REQ-012 Moore FSM with codes FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11; dbg_state equals the current code.
REQ-013 All outputs are combinational from state (plus zero, mem_ready, funct3, funct7 where listed); every output not listed for a state is 0.
REQ-014 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; mem_ready=1 -> DECODE, else hold.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add; next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL.
REQ-016 DECODE -> ILLEGAL for any other op, funct3=011 on op 0110011/0010011, funct3!=010 on load/store, or funct3!=000 on op 1100011.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00 for load, 01 for store; load -> MEMREAD, store -> MEMWRITE.
REQ-018 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; mem_ready=1 -> MEMWB, else hold.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-020 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00; mem_ready=1 -> FETCH, else hold with MemWrite asserted.
REQ-021 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; both -> ALUWB.
REQ-022 ALU function decode per funct3: 000 add (sub only in EXECUTER with funct7=1), 001 sll, 010 slt, 100 xor, 101 srl (sra if funct7=1), 110 or, 111 and.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero -> FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, ImmSrc=11, PCWrite=1 -> ALUWB.
REQ-026 ILLEGAL: illegal=1, all strobes 0, holds until rst.
REQ-027 instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; wraps from all-ones to 0.
REQ-028 Latency (mem_ready=1 throughout): lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-029 rst=1 at a clock edge forces state FETCH, instret 0, illegal 0, from any state including mid-access waits.
REQ-030 Memory strobes during a rst cycle are those of the current state; the following cycle presents FETCH outputs.

Verification
REQ-031 rst, op=0000011 funct3=010, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite only in state 4; instret 0->1.
REQ-032 sw with mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instret unchanged until exit.
REQ-033 op=0110011 funct3=000 funct7=1 -> ALUControl=0001 in EXECUTER; funct3=101 funct7=1 in EXECUTEI -> 1000.
REQ-034 beq zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; jal -> states 0,1,10,8,0.
REQ-035 op=1111111 -> ILLEGAL, illegal=1 held 10 cycles; rst -> illegal=0, dbg_state=0.
REQ-036 instret preloaded to all-ones via retirements (CNT_WIDTH=4, 16 instructions) -> wraps to 0.
